carry_chain_cfg_loader: RTL and testbench
=========================================

CARRY_CHAIN_CFG_LOADER -- requirements
Module: carry_chain_cfg_loader

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- NUM_SLICES, 8, number of fast_carry_chain slices configured.
- CFG_W, 5, config bits per slice; fixed at 5, not overridable.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, single clock; all state changes on the rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, begin a frame load.
- abort, in, 1, cancel the load in progress.
- cfg_bit_valid, in, 1, cfg_bit is valid this cycle.
- cfg_bit, in, 1, serial config data.
- cfg_bit_ready, out, 1, loader accepts cfg_bit this cycle.
- bypass, out, NUM_SLICES, active bypass per slice.
- CYO_MUX_SEL, out, NUM_SLICES, active carry-select-mux control per slice.
- CY0_MUX_SEL, out, 3*NUM_SLICES, active CYMUX0 input select per slice; slice i uses bits [3i+2:3i].
- busy, out, 1, high in LOAD, PARITY and COMMIT.
- done, out, 1, one-cycle pulse on a successful commit.
- err, out, 1, sticky frame error.
REQ-003 Clock and reset SHALL be one clock, clk, with reset synchronous and active-high, named reset.

Function
REQ-004 The state machine SHALL have five states: IDLE, LOAD, PARITY, COMMIT and ERROR.
REQ-005 A bit SHALL be accepted only in a cycle where cfg_bit_valid and cfg_bit_ready are both high.
REQ-006 cfg_bit_ready SHALL be high in LOAD and PARITY and low in every other state.
REQ-007 A frame SHALL be NUM_SLICES*5 data bits followed by one even-parity bit computed over all data bits.
REQ-008 Data bits SHALL arrive slice 0 first, LSB first within each slice, in this order: bypass, CYO_MUX_SEL, CY0_MUX_SEL[0], CY0_MUX_SEL[1], CY0_MUX_SEL[2].
REQ-009 Accepted data bits SHALL go into a shadow register; the active outputs SHALL remain unchanged until COMMIT.
REQ-010 From IDLE, ERROR or after done, start SHALL move the FSM to LOAD, clear the bit counter, clear parity and clear err.
REQ-011 start SHALL be ignored while in LOAD, PARITY or COMMIT.
REQ-012 LOAD SHALL move to PARITY in the cycle after the (NUM_SLICES*5)th data bit is accepted.
- The bit counter width is clog2(NUM_SLICES*5+1).
REQ-013 In PARITY, an accepted parity bit SHALL lead to:
- COMMIT, if the running XOR including the parity bit is 0 and no slice holds an illegal CY0_MUX_SEL code;
- ERROR otherwise.
REQ-014 Legal CY0_MUX_SEL codes SHALL be 0 through 4; codes 5, 6 and 7 in any slice SHALL be illegal.
REQ-015 In COMMIT, which lasts one cycle, the shadow register SHALL be copied to the active outputs.
- The new values SHALL be visible from the next cycle.
- done SHALL be high in that same next cycle only.
- The FSM SHALL then return to IDLE.
REQ-016 Entering ERROR SHALL set err.
- Active outputs SHALL be unchanged.
- err SHALL hold until the next accepted start or until reset.
REQ-017 abort in LOAD or PARITY SHALL return the FSM to IDLE next cycle.
- The shadow register SHALL be discarded.
- Active outputs and err SHALL be unchanged.
REQ-018 abort SHALL be ignored in COMMIT, and the commit SHALL complete.
REQ-019 If abort and start are high in the same cycle, abort SHALL win.
REQ-020 Gaps with cfg_bit_valid low SHALL stall the loader without limit, with no timeout.

Reset
REQ-021 While reset is high, the following SHALL hold:
- state = IDLE;
- bypass = all 1s;
- CYO_MUX_SEL = 0;
- CY0_MUX_SEL = 0;
- shadow register = 0, counter = 0, parity = 0;
- busy = 0, done = 0, err = 0, cfg_bit_ready = 0.
REQ-022 Reset asserted mid-load SHALL discard the partial frame with no commit.
REQ-023 reset SHALL take priority over start and abort.

Structure
REQ-024 A shared package SHALL hold:
- the state enum;
- CFG_W = 5;
- the bit-position constants (BYP=0, CYO=1, CY0_LSB=2);
- CY0_MAX_LEGAL = 4.
REQ-025 One sub-module, cfg_shift_reg, SHALL hold the shadow shift register and its parity accumulator.
REQ-026 The FSM, counter and active registers SHALL live in the top module.

Verification (NUM_SLICES=8, 40 data bits)
REQ-027 Reset release: bypass=8'hFF, CYO_MUX_SEL=0, CY0_MUX_SEL=0, busy=0, done=0, err=0.
REQ-028 Good frame, every slice {CY0=3, CYO=1, bypass=0}, then parity bit 0:
- the cycle after COMMIT shows CY0_MUX_SEL=24'o33333333, CYO_MUX_SEL=8'hFF, bypass=8'h00;
- done=1 for exactly one cycle.
REQ-029 Same frame with the parity bit flipped to 1:
- err=1;
- active outputs keep their prior values;
- next start clears err.
REQ-030 Slice 5 loaded with CY0=6 and otherwise-correct parity:
- ERROR state, err=1;
- no output change.
REQ-031 abort after 20 bits accepted:
- IDLE next cycle, outputs unchanged, done=0;
- a following full good frame commits correctly.
REQ-032 cfg_bit_valid toggled randomly with start pulsed mid-LOAD:
- start is ignored;
- the commit lands after exactly 41 accepted bits.

Source files
------------

// File: rtl/carry_chain_cfg_loader_pkg.sv
// Shared types and constants for the fast_carry_chain configuration loader.
// The per-slice field layout here must match the order in which the serial frame delivers bits.
package carry_chain_cfg_loader_pkg;

    localparam int CFG_W         = 5;
    localparam int BYP           = 0;
    localparam int CYO           = 1;
    localparam int CY0_LSB       = 2;
    localparam int CY0_MAX_LEGAL = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PARITY,
        COMMIT,
        ERROR
    } state_e;

    function automatic logic cy0_is_illegal(input logic [2:0] code);
        return code > 3'(CY0_MAX_LEGAL);
    endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Shadow shift register for one configuration frame, plus a running XOR of every accepted bit.
// Bits shift in at the MSB end, so after a full frame the first bit received sits at bit 0.
module cfg_shift_reg
    import carry_chain_cfg_loader_pkg::*;
#(
    parameter int NUM_SLICES = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear_i,
    input  logic                        shift_i,
    input  logic                        par_i,
    input  logic                        bit_i,
    output logic [NUM_SLICES*CFG_W-1:0] shadow_o,
    output logic                        parity_o
);

    localparam int SR_W = NUM_SLICES * CFG_W;

    logic [SR_W-1:0] shadow_q, shadow_d;
    logic            parity_q, parity_d;

    always_comb begin
        shadow_d = shadow_q;
        parity_d = parity_q;
        if (clear_i) begin
            shadow_d = '0;
            parity_d = 1'b0;
        end else begin
            if (shift_i) begin
                shadow_d = {bit_i, shadow_q[SR_W-1:1]};
            end
            // The parity bit joins the XOR but never enters the shadow image.
            if (shift_i || par_i) begin
                parity_d = parity_q ^ bit_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            parity_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            parity_q <= parity_d;
        end
    end

    assign shadow_o = shadow_q;
    assign parity_o = parity_q;

endmodule

// File: rtl/carry_chain_cfg_loader.sv
// Serial loader for fast_carry_chain slice configuration: collects a parity-protected frame
// in a shadow register and commits it to the active control outputs only when it is clean.
module carry_chain_cfg_loader
    import carry_chain_cfg_loader_pkg::*;
#(
    parameter int NUM_SLICES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    cfg_bit_valid,
    input  logic                    cfg_bit,
    output logic                    cfg_bit_ready,
    output logic [NUM_SLICES-1:0]   bypass,
    output logic [NUM_SLICES-1:0]   CYO_MUX_SEL,
    output logic [3*NUM_SLICES-1:0] CY0_MUX_SEL,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int DATA_BITS = NUM_SLICES * CFG_W;
    localparam int CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    done_q;
    logic [NUM_SLICES-1:0]   bypass_q, cyo_q;
    logic [3*NUM_SLICES-1:0] cy0_q;

    logic                    clear, shift, par, commit, ready;
    logic [DATA_BITS-1:0]    shadow;
    logic                    parity;
    logic                    any_illegal;
    logic [NUM_SLICES-1:0]   byp_sh, cyo_sh;
    logic [3*NUM_SLICES-1:0] cy0_sh;

    cfg_shift_reg #(
        .NUM_SLICES(NUM_SLICES)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (clear),
        .shift_i  (shift),
        .par_i    (par),
        .bit_i    (cfg_bit),
        .shadow_o (shadow),
        .parity_o (parity)
    );

    always_comb begin
        byp_sh      = '0;
        cyo_sh      = '0;
        cy0_sh      = '0;
        any_illegal = 1'b0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            byp_sh[i]      = shadow[i*CFG_W + BYP];
            cyo_sh[i]      = shadow[i*CFG_W + CYO];
            cy0_sh[3*i +: 3] = shadow[i*CFG_W + CY0_LSB +: 3];
            if (cy0_is_illegal(shadow[i*CFG_W + CY0_LSB +: 3])) begin
                any_illegal = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        clear   = 1'b0;
        shift   = 1'b0;
        par     = 1'b0;
        commit  = 1'b0;
        ready   = 1'b0;
        case (state_q)
            IDLE, ERROR: begin
                // abort in the same cycle as start suppresses the start.
                if (start && !abort) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    clear   = 1'b1;
                end
            end
            LOAD: begin
                ready = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    clear   = 1'b1;
                end else if (cfg_bit_valid) begin
                    shift = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                ready = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    clear   = 1'b1;
                end else if (cfg_bit_valid) begin
                    par = 1'b1;
                    if (((parity ^ cfg_bit) == 1'b0) && !any_illegal) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            bypass_q <= '1;
            cyo_q    <= '0;
            cy0_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= commit;
            if (commit) begin
                bypass_q <= byp_sh;
                cyo_q    <= cyo_sh;
                cy0_q    <= cy0_sh;
            end
        end
    end

    assign cfg_bit_ready = ready;
    assign bypass        = bypass_q;
    assign CYO_MUX_SEL   = cyo_q;
    assign CY0_MUX_SEL   = cy0_q;
    assign busy          = (state_q == LOAD) || (state_q == PARITY) || (state_q == COMMIT);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_carry_chain_cfg_loader.sv
// Directed bench for carry_chain_cfg_loader with NUM_SLICES=8 (40 data bits + 1 parity bit).
// Inputs change on the falling edge and outputs are sampled there too.
module tb_carry_chain_cfg_loader;

    logic        clk = 1'b0;
    logic        reset, start, abort, cfg_bit_valid, cfg_bit;
    logic        cfg_bit_ready, busy, done, err;
    logic [7:0]  bypass, CYO_MUX_SEL;
    logic [23:0] CY0_MUX_SEL;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    carry_chain_cfg_loader #(.NUM_SLICES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .cfg_bit_valid (cfg_bit_valid),
        .cfg_bit       (cfg_bit),
        .cfg_bit_ready (cfg_bit_ready),
        .bypass        (bypass),
        .CYO_MUX_SEL   (CYO_MUX_SEL),
        .CY0_MUX_SEL   (CY0_MUX_SEL),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    // Frame images: slice i occupies bits [5i+4:5i] as {CY0[2:0], CYO, bypass}.
    function automatic logic [39:0] pack(input logic [7:0] byp, input logic [7:0] cyo,
                                         input logic [23:0] cy0);
        logic [39:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[i*5]       = byp[i];
            f[i*5+1]     = cyo[i];
            f[i*5+2 +: 3] = cy0[3*i +: 3];
        end
        return f;
    endfunction

    logic [39:0] good_f, var_f, bad_f;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        cfg_bit_valid = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        cfg_bit_valid = 1'b1;
        cfg_bit       = b;
        tick();
        cfg_bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [39:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) send_bit(f[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; abort = 1'b0; cfg_bit_valid = 1'b1; cfg_bit = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy_during got=%b exp=0", busy); end
        checks++; if (cfg_bit_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", cfg_bit_ready); end
        reset = 1'b0; start = 1'b0; cfg_bit_valid = 1'b0;
        tick();
        checks++; if (bypass !== 8'hFF) begin failures++; $display("FAIL rst_bypass got=%h exp=ff", bypass); end
        checks++; if (CYO_MUX_SEL !== 8'h00) begin failures++; $display("FAIL rst_cyo got=%h exp=00", CYO_MUX_SEL); end
        checks++; if (CY0_MUX_SEL !== 24'h0) begin failures++; $display("FAIL rst_cy0 got=%h exp=0", CY0_MUX_SEL); end
        checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {busy, done, err}); end
    endtask

    task automatic test_good_frame();
        pulse_start();
        checks++; if ({busy, cfg_bit_ready} !== 2'b11) begin failures++; $display("FAIL good_load_entry got=%b exp=11", {busy, cfg_bit_ready}); end
        send_bits(good_f, 0, 19);
        checks++; if (bypass !== 8'hFF) begin failures++; $display("FAIL good_shadow_hidden got=%h exp=ff", bypass); end
        send_bits(good_f, 20, 39);
        send_bit(1'b0);
        checks++; if ({busy, done, cfg_bit_ready} !== 3'b100) begin failures++; $display("FAIL good_commit_state got=%b exp=100", {busy, done, cfg_bit_ready}); end
        idle_cycle();
        checks++; if (CY0_MUX_SEL !== 24'o33333333) begin failures++; $display("FAIL good_cy0 got=%o exp=33333333", CY0_MUX_SEL); end
        checks++; if (CYO_MUX_SEL !== 8'hFF) begin failures++; $display("FAIL good_cyo got=%h exp=ff", CYO_MUX_SEL); end
        checks++; if (bypass !== 8'h00) begin failures++; $display("FAIL good_bypass got=%h exp=00", bypass); end
        checks++; if ({done, busy, err} !== 3'b100) begin failures++; $display("FAIL good_done got=%b exp=100", {done, busy, err}); end
        idle_cycle();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL good_done_width got=%b exp=0", done); end
    endtask

    task automatic test_bad_parity();
        pulse_start();
        send_bits(good_f, 0, 39);
        send_bit(1'b1);
        checks++; if ({err, busy} !== 2'b10) begin failures++; $display("FAIL par_err got=%b exp=10", {err, busy}); end
        idle_cycle();
        checks++; if ({err, done} !== 2'b10) begin failures++; $display("FAIL par_err_sticky got=%b exp=10", {err, done}); end
        checks++; if ({bypass, CYO_MUX_SEL, CY0_MUX_SEL} !== {8'h00, 8'hFF, 24'o33333333}) begin
            failures++; $display("FAIL par_outputs got=%h/%h/%o exp=00/ff/33333333", bypass, CYO_MUX_SEL, CY0_MUX_SEL);
        end
        pulse_start();
        checks++; if ({err, busy} !== 2'b01) begin failures++; $display("FAIL par_start_clears got=%b exp=01", {err, busy}); end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_illegal_cy0();
        pulse_start();
        send_bits(bad_f, 0, 39);
        send_bit(1'b0);
        checks++; if ({err, busy} !== 2'b10) begin failures++; $display("FAIL ill_err got=%b exp=10", {err, busy}); end
        idle_cycle();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL ill_no_done got=%b exp=0", done); end
        checks++; if ({bypass, CYO_MUX_SEL, CY0_MUX_SEL} !== {8'h00, 8'hFF, 24'o33333333}) begin
            failures++; $display("FAIL ill_outputs got=%h/%h/%o exp=00/ff/33333333", bypass, CYO_MUX_SEL, CY0_MUX_SEL);
        end
    endtask

    task automatic test_abort();
        pulse_start();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL abort_err_cleared got=%b exp=0", err); end
        send_bits(var_f, 0, 19);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if ({busy, done, cfg_bit_ready, err} !== 4'b0000) begin failures++; $display("FAIL abort_idle got=%b exp=0000", {busy, done, cfg_bit_ready, err}); end
        checks++; if ({bypass, CYO_MUX_SEL, CY0_MUX_SEL} !== {8'h00, 8'hFF, 24'o33333333}) begin
            failures++; $display("FAIL abort_outputs got=%h/%h/%o exp=00/ff/33333333", bypass, CYO_MUX_SEL, CY0_MUX_SEL);
        end
        pulse_start();
        send_bits(var_f, 0, 39);
        send_bit(1'b1);
        idle_cycle();
        checks++; if ({bypass, CYO_MUX_SEL} !== {8'hAA, 8'hCC}) begin failures++; $display("FAIL abort_recommit got=%h/%h exp=aa/cc", bypass, CYO_MUX_SEL); end
        checks++; if (CY0_MUX_SEL !== 24'o21043210) begin failures++; $display("FAIL abort_recommit_cy0 got=%o exp=21043210", CY0_MUX_SEL); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL abort_recommit_done got=%b exp=1", done); end
    endtask

    task automatic test_gapped_start_ignored();
        int  nacc;
        int  cyc;
        logic sent_start;
        logic acc;
        nacc = 0; sent_start = 1'b0;
        pulse_start();
        for (cyc = 0; cyc < 1000 && done !== 1'b1; cyc++) begin
            cfg_bit_valid = (nacc < 41) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_bit       = (nacc < 40) ? good_f[nacc] : 1'b0;
            start         = (nacc == 10 && !sent_start);
            if (start) sent_start = 1'b1;
            acc = cfg_bit_valid && cfg_bit_ready;
            tick();
            if (acc) nacc++;
        end
        start = 1'b0; cfg_bit_valid = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL gap_timeout done=%b exp=1 cycles=%0d", done, cyc); end
        checks++; if (nacc !== 41) begin failures++; $display("FAIL gap_accepted got=%0d exp=41", nacc); end
        checks++; if ({bypass, CYO_MUX_SEL, CY0_MUX_SEL} !== {8'h00, 8'hFF, 24'o33333333}) begin
            failures++; $display("FAIL gap_outputs got=%h/%h/%o exp=00/ff/33333333", bypass, CYO_MUX_SEL, CY0_MUX_SEL);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        send_bits(var_f, 0, 9);
        reset = 1'b1; abort = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; abort = 1'b0; start = 1'b0;
        checks++; if ({bypass, CYO_MUX_SEL, CY0_MUX_SEL} !== {8'hFF, 8'h00, 24'h0}) begin
            failures++; $display("FAIL midrst_outputs got=%h/%h/%o exp=ff/00/0", bypass, CYO_MUX_SEL, CY0_MUX_SEL);
        end
        checks++; if ({busy, cfg_bit_ready, done, err} !== 4'b0000) begin failures++; $display("FAIL midrst_flags got=%b exp=0000", {busy, cfg_bit_ready, done, err}); end
        cfg_bit_valid = 1'b1;
        repeat (5) tick();
        cfg_bit_valid = 1'b0;
        checks++; if ({busy, done, bypass} !== {2'b00, 8'hFF}) begin failures++; $display("FAIL midrst_no_commit got=%b/%h exp=00/ff", {busy, done}, bypass); end
    endtask

    initial begin
        good_f = pack(8'h00, 8'hFF, 24'o33333333);
        var_f  = pack(8'hAA, 8'hCC, 24'o21043210);
        bad_f  = pack(8'h00, 8'hFF, 24'o33633333);
        reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_bit_valid = 1'b0; cfg_bit = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_illegal_cy0();
        test_abort();
        test_gapped_start_ignored();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
